prm_pipe_cce: RTL
=================

# prm_pipe_cce

Parametrised elastic pipeline register: DEPTH cascaded valid/ready stages of WIDTH bits, each with a 2-entry skid buffer so every stage's ready is registered. It adds a synchronous clear (flush) and a global enable. It replaces the plain enable-gated register wherever a datapath needs back-pressure and timing isolation between producer and consumer, e.g. between the decode and execute blocks.

## Interface
- WIDTH, default 8: data width in bits, at least 1.
- DEPTH, default 1: number of cascaded stages, at least 1. Elaboration fails for 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clock clk.
- clr_n  in  1  synchronous active-low flush. Highest priority after rst_n.
- en  in  1  global enable. When 0, all stages freeze.
- in_valid  in  1  producer has data on in_data.
- in_data  in  WIDTH  input word.
- in_ready  out  1  pipeline accepts in_data this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  WIDTH  output word.
- out_ready  in  1  consumer accepts out_data this cycle.
- busy  out  1  at least one stage holds data; also 1 when en=0 and data is held.

## Operation
- Transfers:
  - A transfer occurs on a rising edge when valid and ready are both 1.
  - in_valid must not depend combinationally on in_ready.
  - Data accepted is never lost or duplicated; ordering is preserved.
- Each stage has a main register M, a skid register S and a state:
  - EMPTY: in_valid -> M<=in, go to BUSY.
  - BUSY, in_valid and down_ready -> M<=in, stay in BUSY.
  - BUSY, in_valid and not down_ready -> S<=in, go to FULL.
  - BUSY, not in_valid and down_ready -> go to EMPTY.
  - BUSY, neither -> hold.
  - FULL, down_ready -> M<=S, go to BUSY. No accept in FULL.
  - FULL, not down_ready -> hold.
- Stage outputs:
  - up_ready = (state != FULL), taken straight from the state register.
  - down_valid = (state != EMPTY).
  - down_data = M.
- Stages chain in order: stage 0 connects to in_*, stage DEPTH-1 connects to out_*.
- en=0:
  - in_ready and out_valid are forced to 0.
  - No state or data register changes.
  - busy still reflects held data.
- clr_n=0 at an edge:
  - All stages go to EMPTY; all M and S registers go to 0.
  - This overrides any simultaneous handshake; a word offered that cycle is dropped.
  - en does not need to be 1 for the flush to take effect.
- rst_n=0 at any time, including mid-transfer, has the same effect as a flush, asynchronously.
- Reset values:
  - in_ready=1 (if en=1).
  - out_valid=0, out_data=0, busy=0.
- out_data holds the last M value while out_valid=0. After a reset or flush it is 0.
- Capacity is 2*DEPTH words.

## Timing
- Latency: a word accepted at edge k appears on out_* after edge k+DEPTH-1, with out_valid=1 in the following cycle. Streaming with out_ready=1 gives DEPTH cycles of latency.
- Throughput: 1 word/cycle sustained when out_ready=1 and en=1.
- Back-pressure: when out_ready drops, the pipeline absorbs words until every stage is FULL. in_ready falls no earlier than the cycle after stage 0 enters FULL.
- With continuous in_valid and out_ready=0 from empty, exactly 2*DEPTH words are accepted.
- After out_ready rises, stage 0's in_ready returns to 1 within DEPTH cycles.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- en gating of in_ready and out_valid is combinational (AND gates only).

## Structure
- Shared package holds:
  - The stage-state localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2. Encoding 2'd3 is unreachable and decodes as EMPTY.
  - The RESET constant: WIDTH zeros.
- Sub-module prm_skid_stage has ports clk, rst_n, clr_n, en, up_valid/up_ready/up_data and down_valid/down_ready/down_data.
- The top level instantiates the stage DEPTH times in a generate loop and ORs the per-stage busy signals.

## Test plan
- Reset, then stream 0x01..0x10 with out_ready=1, DEPTH=3 -> first out_valid 3 cycles after the first accept; output sequence 0x01..0x10 with no gaps; in_ready stays at 1.
- DEPTH=2, out_ready=0, in_valid held with incrementing data 0xA0.. -> exactly 4 words accepted and in_ready=0. Then raise out_ready -> 0xA0..0xA3 emerge in order, then streaming resumes.
- Random in_valid/out_ready (50%), WIDTH=16, DEPTH=4, 10k cycles -> scoreboard matches, with no loss, duplication or reordering.
- With 3 words in flight, assert clr_n=0 for one cycle together with in_valid=1 and data 0x55 -> next cycle out_valid=0, busy=0, out_data=0, and 0x55 is never output.
- Pulse en=0 for 5 cycles mid-stream -> in_ready=0 and out_valid=0 for those cycles; busy stays 1; the stream resumes intact afterwards.
- Assert rst_n asynchronously between edges while the pipeline is FULL -> outputs reach reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/prm_pipe_cce_pkg.sv
// Shared definitions for the elastic pipeline register and its skid stages.
package prm_pipe_cce_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Building block of the RESET constant; users replicate it to WIDTH bits.
    localparam logic RESET_BIT = 1'b0;

endpackage

// File: rtl/prm_skid_stage.sv
// One valid/ready stage with a main register and a skid register.
// Because up_ready comes straight from the state register, a long chain of
// these stages has no combinational ready path running back upstream.
module prm_skid_stage
    import prm_pipe_cce_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             en,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RESET = {WIDTH{RESET_BIT}};

    stage_state_e     r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    stage_state_e     w_nextState;
    logic [WIDTH-1:0] w_nextMain;
    logic [WIDTH-1:0] w_nextSkid;

    assign up_ready   = (r_state != ST_FULL);
    assign down_valid = (r_state == ST_BUSY) || (r_state == ST_FULL);
    assign down_data  = r_main;
    assign busy       = down_valid;

    // Next-state logic: flush first, then handshakes only while enabled; the unused encoding behaves as EMPTY.
    always_comb begin
        w_nextState = r_state;
        w_nextMain  = r_main;
        w_nextSkid  = r_skid;
        if (!clr_n) begin
            w_nextState = ST_EMPTY;
            w_nextMain  = RESET;
            w_nextSkid  = RESET;
        end else if (en) begin
            case (r_state)
                ST_BUSY: begin
                    if (up_valid && down_ready) begin
                        w_nextMain = up_data;
                    end else if (up_valid) begin
                        w_nextSkid  = up_data;
                        w_nextState = ST_FULL;
                    end else if (down_ready) begin
                        w_nextState = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (down_ready) begin
                        w_nextMain  = r_skid;
                        w_nextState = ST_BUSY;
                    end
                end
                default: begin
                    if (up_valid) begin
                        w_nextMain  = up_data;
                        w_nextState = ST_BUSY;
                    end
                end
            endcase
        end
    end

    // State and data registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET;
            r_skid  <= RESET;
        end else begin
            r_state <= w_nextState;
            r_main  <= w_nextMain;
            r_skid  <= w_nextSkid;
        end
    end

endmodule

// File: rtl/prm_pipe_cce.sv
// Elastic pipeline register: DEPTH skid stages in a chain, with a flush and a
// global enable. The enable only masks the external handshake outputs; the
// stages themselves freeze internally when it is low.
module prm_pipe_cce
    import prm_pipe_cce_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    if (DEPTH < 1) begin : g_badDepth
        $error("prm_pipe_cce: DEPTH must be at least 1");
    end

    logic [DEPTH:0]   w_valid;
    logic [DEPTH:0]   w_ready;
    logic [WIDTH-1:0] w_data [DEPTH+1];
    logic [DEPTH-1:0] w_stageBusy;

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign w_ready[DEPTH] = out_ready;

    assign in_ready  = en & w_ready[0];
    assign out_valid = en & w_valid[DEPTH];
    assign out_data  = w_data[DEPTH];
    assign busy      = |w_stageBusy;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        prm_skid_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_n      (clr_n),
            .en         (en),
            .up_valid   (w_valid[g]),
            .up_ready   (w_ready[g]),
            .up_data    (w_data[g]),
            .down_valid (w_valid[g+1]),
            .down_ready (w_ready[g+1]),
            .down_data  (w_data[g+1]),
            .busy       (w_stageBusy[g])
        );
    end

endmodule
